// File: rtl/lcd_refresh_ctrl.sv
// HD44780 16x2 refresh engine: power-up wait, init commands,
// then line-by-line copy of the 32-entry character RAM.
module lcd_refresh_ctrl #(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2500,
  parameter int CLEAR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh_en,
  output logic [5:0] char_addr,
  input  logic [7:0] char_data,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic       lcd_on,
  output logic       busy,
  output logic       frame_done
);

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max2(max2(max2(POWERUP_CYC, SETUP_CYC),
                                  max2(EN_HIGH_CYC, CMD_WAIT_CYC)),
                             CLEAR_WAIT_CYC);
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PWR_LAST = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST  = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_L1A, S_L1C,
    S_L2A, S_L2C, S_DONE, S_IDLE
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP, PH_EN, PH_WAIT
  } phase_e;

  state_e          state_q, state_d;
  phase_e          ph_q, ph_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      sub_q, sub_d;
  logic            wr_start;
  logic            wr_act;
  logic [CW-1:0]   wait_last;
  logic [7:0]      cmd_byte;

  logic [5:0]      addr_q, addr_d;
  logic [5:0]      ptr_q, ptr_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            en_q, en_d;
  logic            on_q;
  logic            busy_q, busy_d;
  logic            fd_q, fd_d;

  assign wr_act = (state_q == S_INIT) || (state_q == S_L1A) ||
                  (state_q == S_L1C) || (state_q == S_L2A) ||
                  (state_q == S_L2C);

  // Clear needs the long wait; everything else uses the command wait.
  assign wait_last = ((state_q == S_INIT) && (sub_q == 4'd2)) ?
                     CLR_LAST : CMD_LAST;

  // Command byte for the write currently in progress.
  always_comb begin
    cmd_byte = 8'h00;
    unique case (state_q)
      S_INIT: begin
        unique case (sub_q[1:0])
          2'd0:    cmd_byte = 8'h38;
          2'd1:    cmd_byte = 8'h0C;
          2'd2:    cmd_byte = 8'h01;
          default: cmd_byte = 8'h06;
        endcase
      end
      S_L1A:   cmd_byte = 8'h80;
      S_L2A:   cmd_byte = 8'hC0;
      default: cmd_byte = 8'h00;
    endcase
  end

  // Sequencer state, write phase and cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PWR;
      ph_q    <= PH_SETUP;
      cnt_q   <= '0;
      sub_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
    end
  end

  // Next state: phase timing inside a write, sequence step after WAIT.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q + 1'b1;
    sub_d    = sub_q;
    wr_start = 1'b0;
    unique case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_LAST) begin
          state_d  = S_INIT;
          sub_d    = '0;
          wr_start = 1'b1;
        end
      end
      S_DONE: begin
        cnt_d = cnt_q;
        if (refresh_en) begin
          state_d  = S_L1A;
          wr_start = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        cnt_d = cnt_q;
        if (refresh_en) begin
          state_d  = S_L1A;
          wr_start = 1'b1;
        end
      end
      default: begin
        unique case (ph_q)
          PH_SETUP: begin
            if (cnt_q == SET_LAST) begin
              ph_d  = PH_EN;
              cnt_d = '0;
            end
          end
          PH_EN: begin
            if (cnt_q == EN_LAST) begin
              ph_d  = PH_WAIT;
              cnt_d = '0;
            end
          end
          default: begin
            if (cnt_q == wait_last) begin
              wr_start = 1'b1;
              unique case (state_q)
                S_INIT: begin
                  if (sub_q == 4'd3) begin
                    state_d = S_L1A;
                    sub_d   = '0;
                  end else begin
                    sub_d = sub_q + 4'd1;
                  end
                end
                S_L1A: begin
                  state_d = S_L1C;
                  sub_d   = '0;
                end
                S_L1C: begin
                  if (sub_q == 4'd15) state_d = S_L2A;
                  else sub_d = sub_q + 4'd1;
                end
                S_L2A: begin
                  state_d = S_L2C;
                  sub_d   = '0;
                end
                default: begin
                  if (sub_q == 4'd15) begin
                    state_d  = S_DONE;
                    wr_start = 1'b0;
                  end else begin
                    sub_d = sub_q + 4'd1;
                  end
                end
              endcase
            end
          end
        endcase
      end
    endcase
    if (wr_start) begin
      ph_d  = PH_SETUP;
      cnt_d = '0;
    end
  end

  // Output next values: address/RS at write start, data at first SETUP edge.
  always_comb begin
    addr_d = addr_q;
    ptr_d  = ptr_q;
    rs_d   = rs_q;
    data_d = data_q;
    if (wr_start) begin
      rs_d = (state_d == S_L1C) || (state_d == S_L2C);
      if (state_d == S_L1A) begin
        addr_d = '0;
        ptr_d  = '0;
      end else if (rs_d) begin
        addr_d = ptr_q;
        ptr_d  = ptr_q + 6'd1;
      end
    end
    if (wr_act && (ph_q == PH_SETUP) && (cnt_q == '0)) begin
      data_d = rs_q ? char_data : cmd_byte;
    end
    en_d   = (ph_d == PH_EN);
    busy_d = (state_d != S_IDLE);
    fd_d   = (state_d == S_DONE);
  end

  // Registered LCD bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      ptr_q  <= '0;
      data_q <= 8'h00;
      rs_q   <= 1'b0;
      en_q   <= 1'b0;
      on_q   <= 1'b0;
      busy_q <= 1'b1;
      fd_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      ptr_q  <= ptr_d;
      data_q <= data_d;
      rs_q   <= rs_d;
      en_q   <= en_d;
      on_q   <= 1'b1;
      busy_q <= busy_d;
      fd_q   <= fd_d;
    end
  end

  assign char_addr  = addr_q;
  assign lcd_data   = data_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_en     = en_q;
  assign lcd_on     = on_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Directed bench for lcd_refresh_ctrl: init timing, frame
// contents, idle/restart, RAM update timing, mid-write reset.
module tb_lcd_refresh_ctrl;

  localparam int NS = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       refresh_en;
  logic [5:0] char_addr;
  logic [7:0] char_data;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;
  logic       busy;
  logic       frame_done;

  logic [7:0] ram [0:63];
  logic [7:0] icmd [0:3];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nstr = 0;
  int rise [0:NS-1];
  int fall [0:NS-1];
  logic [7:0] sdata [0:NS-1];
  logic srs [0:NS-1];
  logic en_prev = 1'b0;
  logic fd_prev = 1'b0;
  int fd_hi = 0;
  int fd_pulse = 0;
  int fd_cyc = 0;
  int r0, n1;

  assign char_data = ram[char_addr];

  lcd_refresh_ctrl #(
    .POWERUP_CYC   (20),
    .SETUP_CYC     (2),
    .EN_HIGH_CYC   (3),
    .CMD_WAIT_CYC  (5),
    .CLEAR_WAIT_CYC(12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .refresh_en(refresh_en),
    .char_addr (char_addr),
    .char_data (char_data),
    .lcd_data  (lcd_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_on    (lcd_on),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lcd_en && !en_prev) begin
      if (nstr < NS) begin
        rise[nstr]  = cyc;
        sdata[nstr] = lcd_data;
        srs[nstr]   = lcd_rs;
      end
      nstr++;
    end
    if (!lcd_en && en_prev && nstr > 0 && nstr <= NS)
      fall[nstr-1] = cyc;
    if (frame_done) begin
      fd_hi++;
      if (!fd_prev) begin
        fd_pulse++;
        fd_cyc = cyc;
      end
    end
    en_prev = lcd_en;
    fd_prev = frame_done;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_str(input int n, input int budget, input string tag);
    int k = 0;
    while (nstr < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, (nstr >= n), 1'b1);
  endtask

  task automatic wait_fd(input int n, input int budget, input string tag);
    int k = 0;
    while (fd_pulse < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk(tag, (fd_pulse >= n), 1'b1);
  endtask

  task automatic check_frame(input int base, input logic [7:0] a5);
    logic [7:0] ed;
    logic er;
    for (int j = 0; j < 34; j++) begin
      if (j == 0) begin
        ed = 8'h80; er = 1'b0;
      end else if (j == 17) begin
        ed = 8'hC0; er = 1'b0;
      end else if (j < 17) begin
        ed = 8'(8'h41 + j - 1); er = 1'b1;
      end else begin
        ed = 8'(8'h51 + j - 18); er = 1'b1;
      end
      if (j == 6) ed = a5;
      chk($sformatf("frm%0d_data%0d", base, j), sdata[base+j], ed);
      chk($sformatf("frm%0d_rs%0d", base, j), srs[base+j], er);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_addr"}, char_addr, 6'd0);
    chk({p, "_data"}, lcd_data, 8'h00);
    chk({p, "_rs"}, lcd_rs, 1'b0);
    chk({p, "_rw"}, lcd_rw, 1'b0);
    chk({p, "_en"}, lcd_en, 1'b0);
    chk({p, "_on"}, lcd_on, 1'b0);
    chk({p, "_busy"}, busy, 1'b1);
    chk({p, "_fd"}, frame_done, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'(8'h41 + i);
    icmd[0] = 8'h38;
    icmd[1] = 8'h0C;
    icmd[2] = 8'h01;
    icmd[3] = 8'h06;
    rst_n = 1'b1;
    refresh_en = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_reset("rst0");

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = cyc;
    wait_str(4, 400, "init_timeout");
    chk("pwr_quiet", rise[0] - r0, 22);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("init_cmd%0d", i), sdata[i], icmd[i]);
      chk($sformatf("init_rs%0d", i), srs[i], 1'b0);
    end
    chk("en_width", fall[0] - rise[0], 3);
    chk("gap_38_0c", rise[1] - rise[0], 10);
    chk("gap_0c_01", rise[2] - rise[1], 10);
    chk("clr_elow", rise[3] - fall[2] - 2, 12);
    chk("gap_01_06", rise[3] - rise[2], 17);

    wait_fd(1, 1000, "frame0_timeout");
    chk("frame0_strobes", nstr, 38);
    chk("gap_06_80", rise[4] - rise[3], 10);
    check_frame(4, 8'h46);
    chk("fd_delay", fd_cyc - rise[37], 8);
    repeat (20) @(negedge clk);
    #1;
    chk("idle_busy", busy, 1'b0);
    chk("idle_no_en", nstr, 38);
    chk("fd_pulses0", fd_pulse, 1);
    chk("fd_width0", fd_hi, 1);

    refresh_en = 1'b1;
    @(negedge clk);
    #1;
    chk("wake_busy", busy, 1'b1);
    wait_str(39, 100, "wake_timeout");
    chk("wake_cmd", sdata[38], 8'h80);
    chk("wake_rs", srs[38], 1'b0);

    wait_str(45, 200, "a5_timeout");
    ram[5] = 8'h5A;
    wait_fd(3, 2000, "frame2_timeout");
    chk("frames12_strobes", nstr, 106);
    check_frame(38, 8'h46);
    check_frame(72, 8'h5A);
    chk("fd_pulses", fd_pulse, 3);
    chk("fd_width", fd_hi, 3);

    wait_str(125, 400, "l2_timeout");
    chk("pre_rst_en", lcd_en, 1'b1);
    chk("pre_rst_data", sdata[124], 8'h51);
    chk("pre_rst_rs", srs[124], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_reset("rst1");
    @(negedge clk);
    rst_n = 1'b1;
    r0 = cyc;
    n1 = nstr;
    wait_str(n1 + 1, 100, "rst1_timeout");
    chk("rst1_quiet", rise[n1] - r0, 22);
    chk("rst1_cmd", sdata[n1], 8'h38);
    chk("rst1_rs", srs[n1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
